// File: rtl/spell_mem_arb_pkg.sv
// Shared types and widths for the two-port memory arbiter.
package spell_mem_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;
endpackage

// File: rtl/spell_arb_rr2.sv
// Two-requester grant selection: round-robin on contention, or fixed priority to port 0.
module spell_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      // last=1 means port 1 won previously, so port 0 goes next
      2'b11: gnt = (rr_en && !last) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/spell_mem_arbiter.sv
// Arbitrates two requesters onto one memory port; all outputs registered.
//   state   | meaning
//   IDLE    | waiting for a request; grants and launches the command on the same edge
//   ACCESS  | command held on mem_*; waits for data_ready or the timeout
//   RELEASE | one cycle with mem_select low so the memory drops data_ready
module spell_mem_arbiter
  import spell_mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int ROUND_ROBIN    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_type,
  input  logic              p0_write,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_type,
  input  logic              p1_write,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_type,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_ready,
  output logic              busy
);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = TIMEOUT_CYCLES[CNT_W-1:0];
  localparam logic             RR_EN       = (ROUND_ROBIN != 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt1_q, gnt1_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              type_q, type_d;
  logic              write_q, write_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic [1:0]        gnt;

  spell_arb_rr2 u_arb (
    .req   ({p1_req, p0_req}),
    .last  (last_q),
    .rr_en (RR_EN),
    .gnt   (gnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt1_q   <= 1'b0;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      type_q   <= 1'b0;
      write_q  <= 1'b0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt1_q   <= gnt1_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      type_q   <= type_d;
      write_q  <= write_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt1_d   = gnt1_q;
    last_d   = last_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    type_d   = type_q;
    write_d  = write_q;
    ack_d    = '0;
    err_d    = '0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt[0]) begin
          gnt1_d  = 1'b0;
          last_d  = 1'b0;
          sel_d   = 1'b1;
          addr_d  = p0_addr;
          wdata_d = p0_wdata;
          type_d  = p0_type;
          write_d = p0_write;
          state_d = ACCESS;
        end else if (gnt[1]) begin
          gnt1_d  = 1'b1;
          last_d  = 1'b1;
          sel_d   = 1'b1;
          addr_d  = p1_addr;
          wdata_d = p1_wdata;
          type_d  = p1_type;
          write_d = p1_write;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // data_ready is checked first so it wins over a coincident timeout
        if (mem_data_ready || (cnt_q == TIMEOUT_CNT)) begin
          sel_d   = 1'b0;
          state_d = RELEASE;
          if (gnt1_q) begin
            ack_d[1] = 1'b1;
            err_d[1] = ~mem_data_ready;
            if (!mem_data_ready)  rdata1_d = '0;
            else if (!write_q)    rdata1_d = mem_data_out;
          end else begin
            ack_d[0] = 1'b1;
            err_d[0] = ~mem_data_ready;
            if (!mem_data_ready)  rdata0_d = '0;
            else if (!write_q)    rdata0_d = mem_data_out;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign p0_ack      = ack_q[0];
  assign p1_ack      = ack_q[1];
  assign p0_err      = err_q[0];
  assign p1_err      = err_q[1];
  assign p0_rdata    = rdata0_q;
  assign p1_rdata    = rdata1_q;
  assign mem_select  = sel_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_type    = type_q;
  assign mem_write   = write_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Directed bench: round-robin arbiter on a memory model with configurable latency,
// plus a fixed-priority instance sharing the requester stimulus.
module tb_spell_mem_arbiter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       p0_req = 1'b0, p0_type = 1'b0, p0_write = 1'b0;
  logic [7:0] p0_addr = '0, p0_wdata = '0;
  logic       p1_req = 1'b0, p1_type = 1'b0, p1_write = 1'b0;
  logic [7:0] p1_addr = '0, p1_wdata = '0;

  logic       p0_ack, p0_err, p1_ack, p1_err, busy;
  logic [7:0] p0_rdata, p1_rdata;
  logic       mem_select, mem_type, mem_write, mem_data_ready;
  logic [7:0] mem_addr, mem_data_in, mem_data_out;

  logic       fp_p0_ack, fp_p0_err, fp_p1_ack, fp_p1_err, fp_busy;
  logic [7:0] fp_p0_rdata, fp_p1_rdata;
  logic       fp_mem_select, fp_mem_type, fp_mem_write, fp_mem_data_ready;
  logic [7:0] fp_mem_addr, fp_mem_data_in, fp_mem_data_out;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_delay = 0;
  bit mem_never = 1'b0;
  int dly_cnt;

  logic [7:0] code_mem [256];
  logic [7:0] data_mem [8];

  always #5 clock = ~clock;

  spell_mem_arbiter #(.TIMEOUT_CYCLES(15), .ROUND_ROBIN(1)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_type(p0_type), .p0_write(p0_write),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_type(p1_type), .p1_write(p1_write),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_type(mem_type),
    .mem_write(mem_write), .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready), .busy(busy)
  );

  spell_mem_arbiter #(.TIMEOUT_CYCLES(15), .ROUND_ROBIN(0)) dut_fp (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_type(p0_type), .p0_write(p0_write),
    .p0_ack(fp_p0_ack), .p0_err(fp_p0_err), .p0_rdata(fp_p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_type(p1_type), .p1_write(p1_write),
    .p1_ack(fp_p1_ack), .p1_err(fp_p1_err), .p1_rdata(fp_p1_rdata),
    .mem_select(fp_mem_select), .mem_addr(fp_mem_addr), .mem_data_in(fp_mem_data_in), .mem_type(fp_mem_type),
    .mem_write(fp_mem_write), .mem_data_out(fp_mem_data_out), .mem_data_ready(fp_mem_data_ready), .busy(fp_busy)
  );

  initial begin
    for (int i = 0; i < 256; i++) code_mem[i] = 8'(i);
    code_mem[5] = 8'hA7;
    code_mem[6] = 8'h5E;
  end

  // Memory model: ready rises mem_delay cycles after select is first seen; data memory holds 8 bytes
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_data_ready <= 1'b0;
      mem_data_out   <= '0;
      dly_cnt        <= 0;
      for (int i = 0; i < 8; i++) data_mem[i] <= '0;
    end else if (!mem_select) begin
      mem_data_ready <= 1'b0;
      dly_cnt        <= 0;
    end else if (!mem_data_ready && !mem_never) begin
      if (dly_cnt == mem_delay) begin
        mem_data_ready <= 1'b1;
        if (mem_type) begin
          if (mem_addr < 8'd8) begin
            if (mem_write) data_mem[mem_addr[2:0]] <= mem_data_in;
            else           mem_data_out <= data_mem[mem_addr[2:0]];
          end else if (!mem_write) begin
            mem_data_out <= 8'h00;
          end
        end else if (!mem_write) begin
          mem_data_out <= code_mem[mem_addr];
        end
      end else begin
        dly_cnt <= dly_cnt + 1;
      end
    end
  end

  // Zero-wait echo memory for the fixed-priority instance
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      fp_mem_data_ready <= 1'b0;
      fp_mem_data_out   <= '0;
    end else begin
      fp_mem_data_ready <= fp_mem_select;
      fp_mem_data_out   <= (fp_mem_write || fp_mem_type) ? fp_mem_data_in : fp_mem_addr;
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0;
    mem_never = 1'b0; mem_delay = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_ack(input int port, input int max_cyc, output int n, output bit seen);
    seen = 1'b0;
    n = 0;
    while (!seen && n < max_cyc) begin
      @(negedge clock);
      n++;
      if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) seen = 1'b1;
    end
  endtask

  // Starts from an idle sampling point; n counts sampling points from the request to the ack
  task automatic do_access(input int port, input logic typ, input logic wr, input logic [7:0] addr,
                           input logic [7:0] wdata, input int max_cyc, output int n, output bit seen);
    @(negedge clock);
    if (port == 0) begin
      p0_type = typ; p0_write = wr; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end else begin
      p1_type = typ; p1_write = wr; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end
    wait_ack(port, max_cyc, n, seen);
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (mem_select !== 1'b0) begin n_fail++; $display("FAIL reset_select: got %b want 0", mem_select); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if ({p0_ack, p1_ack, p0_err, p1_err} !== 4'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b want 0000", {p0_ack, p1_ack, p0_err, p1_err}); end
    n_checks++; if ({p0_rdata, p1_rdata} !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", {p0_rdata, p1_rdata}); end
    n_checks++; if ({mem_addr, mem_data_in, mem_type, mem_write} !== 18'h0) begin n_fail++; $display("FAIL reset_mem_cmd: got %h want 0", {mem_addr, mem_data_in, mem_type, mem_write}); end
  endtask

  task automatic test_single_read();
    int n; bit seen;
    apply_reset();
    do_access(0, 1'b0, 1'b0, 8'h05, 8'h00, 40, n, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL single_ack_seen: got %b want 1", seen); end
    // grant edge, one ACCESS cycle with ready rising, ack on the next edge
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL single_latency: got %0d want 3", n); end
    n_checks++; if (p0_rdata !== 8'hA7) begin n_fail++; $display("FAIL single_rdata: got %h want a7", p0_rdata); end
    n_checks++; if (p0_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", p0_err); end
    n_checks++; if (p1_ack !== 1'b0) begin n_fail++; $display("FAIL single_p1_ack: got %b want 0", p1_ack); end
    @(negedge clock);
    n_checks++; if (p0_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0", p0_ack); end
    n_checks++; if (p0_rdata !== 8'hA7) begin n_fail++; $display("FAIL single_rdata_hold: got %h want a7", p0_rdata); end
  endtask

  task automatic test_write_readback();
    int n; bit seen;
    apply_reset();
    do_access(1, 1'b1, 1'b1, 8'h02, 8'h3C, 40, n, seen);
    n_checks++; if (seen !== 1'b1 || p1_err !== 1'b0) begin n_fail++; $display("FAIL wr02_ack: got seen=%b err=%b want 1/0", seen, p1_err); end
    n_checks++; if (p1_rdata !== 8'h00) begin n_fail++; $display("FAIL wr02_rdata_unchanged: got %h want 00", p1_rdata); end
    do_access(1, 1'b1, 1'b0, 8'h02, 8'h00, 40, n, seen);
    n_checks++; if (seen !== 1'b1 || p1_rdata !== 8'h3C) begin n_fail++; $display("FAIL rd02: got seen=%b rdata=%h want 1/3c", seen, p1_rdata); end
    do_access(1, 1'b1, 1'b1, 8'h09, 8'h55, 40, n, seen);
    n_checks++; if (seen !== 1'b1 || p1_rdata !== 8'h3C) begin n_fail++; $display("FAIL wr09: got seen=%b rdata=%h want 1/3c", seen, p1_rdata); end
    do_access(1, 1'b1, 1'b0, 8'h09, 8'h00, 40, n, seen);
    n_checks++; if (seen !== 1'b1 || p1_rdata !== 8'h00) begin n_fail++; $display("FAIL rd09: got seen=%b rdata=%h want 1/00", seen, p1_rdata); end
    n_checks++; if (p0_rdata !== 8'h00) begin n_fail++; $display("FAIL wrrd_p0_untouched: got %h want 00", p0_rdata); end
  endtask

  task automatic test_timeout();
    int n; bit seen;
    apply_reset();
    do_access(0, 1'b0, 1'b0, 8'h05, 8'h00, 40, n, seen);
    mem_never = 1'b1;
    do_access(0, 1'b0, 1'b0, 8'h05, 8'h00, 40, n, seen);
    // counter runs 0..15 across 16 ACCESS cycles, abort on the edge where it reads 15
    n_checks++; if (seen !== 1'b1 || n !== 17) begin n_fail++; $display("FAIL timeout_latency: got seen=%b n=%0d want 1/17", seen, n); end
    n_checks++; if (p0_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", p0_err); end
    n_checks++; if (p0_rdata !== 8'h00) begin n_fail++; $display("FAIL timeout_rdata: got %h want 00", p0_rdata); end
    n_checks++; if ({busy, mem_select} !== 2'b10) begin n_fail++; $display("FAIL timeout_release: got busy,sel=%b want 10", {busy, mem_select}); end
    @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got busy=%b want 0", busy); end
    mem_never = 1'b0;
  endtask

  task automatic test_ready_wins();
    int n; bit seen;
    apply_reset();
    mem_delay = 14;
    do_access(0, 1'b0, 1'b0, 8'h05, 8'h00, 40, n, seen);
    n_checks++; if (seen !== 1'b1 || n !== 17) begin n_fail++; $display("FAIL tie_latency: got seen=%b n=%0d want 1/17", seen, n); end
    n_checks++; if ({p0_err, p0_rdata} !== {1'b0, 8'hA7}) begin n_fail++; $display("FAIL tie_ready_wins: got err=%b rdata=%h want 0/a7", p0_err, p0_rdata); end
  endtask

  task automatic test_delayed();
    int n; bit seen; int low_busy;
    logic [2:0] sel_seq;
    apply_reset();
    mem_delay = 3;
    do_access(0, 1'b0, 1'b0, 8'h05, 8'h00, 40, n, seen);
    n_checks++; if (seen !== 1'b1 || n !== 6) begin n_fail++; $display("FAIL delayed_latency: got seen=%b n=%0d want 1/6", seen, n); end
    n_checks++; if (p0_rdata !== 8'hA7) begin n_fail++; $display("FAIL delayed_rdata: got %h want a7", p0_rdata); end
    p0_req = 1'b1;
    low_busy = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clock);
      sel_seq[i] = mem_select;
      if (busy && !mem_select) low_busy++;
    end
    n_checks++; if (low_busy !== 1) begin n_fail++; $display("FAIL delayed_release_len: got %0d want 1", low_busy); end
    n_checks++; if (sel_seq !== 3'b100) begin n_fail++; $display("FAIL delayed_sel_seq: got %b want 100", sel_seq); end
    wait_ack(0, 40, n, seen);
    p0_req = 1'b0;
    n_checks++; if (seen !== 1'b1 || n !== 5) begin n_fail++; $display("FAIL delayed_second: got seen=%b n=%0d want 1/5", seen, n); end
  endtask

  task automatic test_contention();
    int k; int fp0; int fp1;
    logic prev0, prev1;
    logic [3:0] order;
    int t [4];
    apply_reset();
    p0_type = 1'b0; p0_write = 1'b0; p0_addr = 8'h05;
    p1_type = 1'b0; p1_write = 1'b0; p1_addr = 8'h06;
    k = 0; fp0 = 0; fp1 = 0; prev0 = 1'b0; prev1 = 1'b0; order = '0;
    for (int i = 0; i < 4; i++) t[i] = 0;
    @(negedge clock);
    p0_req = 1'b1; p1_req = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      n_checks++; if (p0_ack && p1_ack) begin n_fail++; $display("FAIL both_ack: cycle %0d got 11 want not both", c); end
      n_checks++; if ((p0_ack && prev0) || (p1_ack && prev1)) begin n_fail++; $display("FAIL ack_pulse_len: cycle %0d got 2-cycle ack want 1", c); end
      prev0 = p0_ack; prev1 = p1_ack;
      if ((p0_ack || p1_ack) && k < 4) begin order[k] = p1_ack; t[k] = c; k++; end
      if (fp_p0_ack) fp0++;
      if (fp_p1_ack) fp1++;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    n_checks++; if (k !== 4) begin n_fail++; $display("FAIL rr_grants: got %0d want 4", k); end
    n_checks++; if (order !== 4'b1010) begin n_fail++; $display("FAIL rr_order: got %b want 1010 (msb=4th)", order); end
    n_checks++; if (t[0] !== 3 || t[1] !== 7 || t[2] !== 11 || t[3] !== 15) begin n_fail++; $display("FAIL rr_spacing: got %0d %0d %0d %0d want 3 7 11 15", t[0], t[1], t[2], t[3]); end
    n_checks++; if (p0_rdata !== 8'hA7 || p1_rdata !== 8'h5E) begin n_fail++; $display("FAIL rr_rdata: got %h %h want a7 5e", p0_rdata, p1_rdata); end
    n_checks++; if (fp0 !== 4 || fp1 !== 0) begin n_fail++; $display("FAIL fixed_prio: got p0=%0d p1=%0d want 4/0", fp0, fp1); end
    n_checks++; if (fp_p0_rdata !== 8'h05 || fp_p0_err !== 1'b0) begin n_fail++; $display("FAIL fixed_rdata: got %h err=%b want 05/0", fp_p0_rdata, fp_p0_err); end
  endtask

  task automatic test_reset_mid_access();
    int acks; bit seen; int n;
    apply_reset();
    mem_delay = 5;
    @(negedge clock);
    p0_type = 1'b0; p0_write = 1'b0; p0_addr = 8'h05; p0_req = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++; if ({busy, mem_select} !== 2'b11) begin n_fail++; $display("FAIL midrst_pre: got busy,sel=%b want 11", {busy, mem_select}); end
    reset = 1'b1;
    #1;
    n_checks++; if (mem_select !== 1'b0) begin n_fail++; $display("FAIL midrst_select: got %b want 0", mem_select); end
    n_checks++; if (busy !== 1'b0 || p0_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_ack: got busy=%b ack=%b want 0/0", busy, p0_ack); end
    p0_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (p0_ack || p1_ack) acks++;
    end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL midrst_no_ack: got %0d want 0", acks); end
    p1_type = 1'b0; p1_write = 1'b0; p1_addr = 8'h06;
    p0_req = 1'b1; p1_req = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(negedge clock);
      n++;
      if (p0_ack || p1_ack) seen = 1'b1;
    end
    n_checks++; if ({seen, p0_ack, p1_ack} !== 3'b110) begin n_fail++; $display("FAIL midrst_first_grant: got seen,a0,a1=%b want 110", {seen, p0_ack, p1_ack}); end
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_readback();
    test_timeout();
    test_ready_wins();
    test_delayed();
    test_contention();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
